// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MDU_LAST = 2'd2
  } state_t;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int REG_ZERO       = 0;

  // Legal MDU occupancy; the 4-bit down-counter holds at most MDU_LAT-2.
  localparam int MDU_LAT_MIN = 2;
  localparam int MDU_LAT_MAX = 16;

endpackage

// File: rtl/hazard_stall_controller_mdu_stall_fsm.sv
// MDU occupancy sequencer: freezes upstream for MDU_LAT-1 cycles, then flags the final EX cycle.
module mdu_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mduStart,
  output logic mduStall,
  output logic MduDone
);

  localparam logic [3:0] CNT_LOAD = 4'(MDU_LAT - 2);

  generate
    if (MDU_LAT < MDU_LAT_MIN || MDU_LAT > MDU_LAT_MAX) begin : gBadLat
      $error("mdu_stall_fsm: MDU_LAT out of range 2..16");
    end
  endgenerate

  state_t     state_r;
  logic [3:0] cnt_r;
  logic       mduDone_r;

  // State, counter and the registered final-cycle flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= RUN;
      cnt_r     <= 4'd0;
      mduDone_r <= 1'b0;
    end else begin
      mduDone_r <= 1'b0;
      case (state_r)
        RUN: begin
          if (mduStart) begin
            cnt_r <= CNT_LOAD;
            if (CNT_LOAD == 4'd0) begin
              state_r   <= MDU_LAST;
              mduDone_r <= 1'b1;
            end else begin
              state_r <= MDU_WAIT;
            end
          end
        end
        MDU_WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_r   <= MDU_LAST;
            mduDone_r <= 1'b1;
          end
        end
        MDU_LAST: begin
          // The op occupying EX is the one that started this run; its start flag is ignored here.
          state_r <= RUN;
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // Stall is combinational on the start flag so the first MDU cycle freezes upstream immediately
  always_comb begin
    mduStall = 1'b0;
    if (state_r == MDU_WAIT) begin
      mduStall = 1'b1;
    end else if (state_r == RUN) begin
      mduStall = mduStart;
    end else begin
      mduStall = 1'b0;
    end
  end

  assign MduDone = mduDone_r;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use, branch-in-ID, taken-branch flush and MDU occupancy.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MDU_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
  input  logic                  IF_ID_UsesRt,
  input  logic                  IF_ID_Branch,
  input  logic                  ID_BranchTaken,
  input  logic                  ID_EX_RegWrite,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegisterDst,
  input  logic                  ID_EX_MduStart,
  input  logic                  EX_MEM_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_MEM_RegisterDst,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Bubble,
  output logic                  ID_EX_Hold,
  output logic                  EX_MEM_Bubble,
  output logic                  MduDone,
  output logic [15:0]           StallCycles,
  output logic [15:0]           FlushCount
);

  function automatic logic regMatch(input logic [REG_ADDR_W-1:0] d,
                                    input logic [REG_ADDR_W-1:0] rs,
                                    input logic [REG_ADDR_W-1:0] rt,
                                    input logic                  usesRt);
    return (d != REG_ADDR_W'(REG_ZERO)) && ((d == rs) || (usesRt && (d == rt)));
  endfunction

  logic mduStall_s;
  logic loadUse_s;
  logic brStall_s;
  logic dataStall_s;
  logic flush_s;

  mdu_stall_fsm #(
    .MDU_LAT (MDU_LAT)
  ) uMduFsm (
    .clk      (clk),
    .reset    (reset),
    .mduStart (ID_EX_MduStart),
    .mduStall (mduStall_s),
    .MduDone  (MduDone)
  );

  // Hazard detection; MDU stall outranks data stall, which outranks flush
  always_comb begin
    loadUse_s = ID_EX_MemRead &&
                regMatch(ID_EX_RegisterDst, IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt);
    brStall_s = IF_ID_Branch &&
                ((ID_EX_RegWrite &&
                  regMatch(ID_EX_RegisterDst, IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt)) ||
                 (EX_MEM_MemRead &&
                  regMatch(EX_MEM_RegisterDst, IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt)));
    dataStall_s = !mduStall_s && (loadUse_s || brStall_s);
    flush_s     = !mduStall_s && !dataStall_s && ID_BranchTaken;
  end

  // Pipeline control outputs
  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    ID_EX_Hold    = 1'b0;
    EX_MEM_Bubble = 1'b0;
    if (reset) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Bubble  = 1'b1;
      EX_MEM_Bubble = 1'b1;
    end else if (mduStall_s) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Hold    = 1'b1;
      EX_MEM_Bubble = 1'b1;
    end else if (dataStall_s) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (flush_s) begin
      IF_ID_Flush = 1'b1;
      PCWrite     = 1'b1;
    end else begin
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stallCycles_r;
  logic [15:0] flushCount_r;

  // Saturating stall/flush event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCycles_r <= 16'd0;
      flushCount_r  <= 16'd0;
    end else begin
      if ((mduStall_s || dataStall_s) && (stallCycles_r != 16'hFFFF)) begin
        stallCycles_r <= stallCycles_r + 16'd1;
      end
      if (flush_s && (flushCount_r != 16'hFFFF)) begin
        flushCount_r <= flushCount_r + 16'd1;
      end
    end
  end

  assign StallCycles = stallCycles_r;
  assign FlushCount  = flushCount_r;
`else
  assign StallCycles = 16'd0;
  assign FlushCount  = 16'd0;
`endif

endmodule
